// File: rtl/multu_unit_pkg.sv
// Shared definitions for the multu_unit HI/LO multiplier: FSM state encodings,
// the default operand width and the funct codes shared with the ALU control decoder.
package multu_unit_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [5:0] F_multu = 6'h19;
    localparam logic [5:0] F_mfhi  = 6'h10;
    localparam logic [5:0] F_mflo  = 6'h12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multu_unit_if.sv
// Handshake and operand/result bundle between the pipeline control and multu_unit.
interface multu_unit_if #(parameter int WIDTH = multu_unit_pkg::WIDTH_DEF);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, output a, output b,
                    input busy, input done, input hi, input lo);
    modport slave  (input start, input a, input b,
                    output busy, output done, output hi, output lo);

endinterface

// File: rtl/multu_dp.sv
// Shift-add datapath for multu_unit: multiplicand/multiplier/product registers,
// the adder, and the HI/LO result registers. With MULTU_EARLY_EXIT_EN it also reports mplier == 0.
module multu_dp #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             commit,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef MULTU_EARLY_EXIT_EN
    output logic             mplier_zero,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [2*WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [2*WIDTH-1:0] prod_r;
    logic [2*WIDTH-1:0] prod_next_s;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    // Conditional add of the shifted multiplicand for the current multiplier bit.
    always_comb begin
        prod_next_s = prod_r;
        if (mplier_r[0]) begin
            prod_next_s = prod_r + mcand_r;
        end else begin
            prod_next_s = prod_r;
        end
    end

    // Operand load, per-iteration shift/accumulate and result commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_r  <= {(2*WIDTH){1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            prod_r   <= {(2*WIDTH){1'b0}};
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
        end else begin
            if (load) begin
                mcand_r  <= {{WIDTH{1'b0}}, a};
                mplier_r <= b;
                prod_r   <= {(2*WIDTH){1'b0}};
            end else if (step) begin
                mcand_r  <= mcand_r << 1;
                mplier_r <= mplier_r >> 1;
                prod_r   <= prod_next_s;
            end
            // When committing on an exhausted multiplier no add happens, so prod_next equals prod.
            if (commit) begin
                hi_r <= prod_next_s[2*WIDTH-1:WIDTH];
                lo_r <= prod_next_s[WIDTH-1:0];
            end
        end
    end

`ifdef MULTU_EARLY_EXIT_EN
    assign mplier_zero = (mplier_r == {WIDTH{1'b0}});
`endif
    assign hi = hi_r;
    assign lo = lo_r;

endmodule

// File: rtl/multu_unit.sv
// Sequential unsigned multiplier (MIPS multu) owning HI/LO, one multiplier bit per cycle.
// Optional feature macro: MULTU_EARLY_EXIT_EN finishes as soon as the remaining multiplier is zero.
module multu_unit
    import multu_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst,
    multu_unit_if.slave   bus
);

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             busy_r;
    logic             done_r;
    logic             load_s;
    logic             step_s;
    logic             commit_s;
    logic [WIDTH-1:0] hi_s;
    logic [WIDTH-1:0] lo_s;
`ifdef MULTU_EARLY_EXIT_EN
    logic             mplier_zero_s;
`endif

    multu_dp #(.WIDTH(WIDTH)) u_dp (
        .clk         (clk),
        .rst         (rst),
        .load        (load_s),
        .step        (step_s),
        .commit      (commit_s),
        .a           (bus.a),
        .b           (bus.b),
`ifdef MULTU_EARLY_EXIT_EN
        .mplier_zero (mplier_zero_s),
`endif
        .hi          (hi_s),
        .lo          (lo_s)
    );

    // Next-state, counter and datapath strobes.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        commit_s     = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    load_s       = 1'b1;
                    cnt_next_s   = {CNT_W{1'b0}};
                    state_next_s = ST_BUSY;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
`ifdef MULTU_EARLY_EXIT_EN
                if (mplier_zero_s) begin
                    commit_s     = 1'b1;
                    state_next_s = ST_DONE;
                end else begin
                    step_s     = 1'b1;
                    cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_r == CNT_W'(WIDTH-1)) begin
                        commit_s     = 1'b1;
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_BUSY;
                    end
                end
`else
                step_s     = 1'b1;
                cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_r == CNT_W'(WIDTH-1)) begin
                    commit_s     = 1'b1;
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_BUSY;
                end
`endif
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, counter and registered busy/done flags (flags track the next state).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            busy_r  <= (state_next_s == ST_BUSY);
            done_r  <= (state_next_s == ST_DONE);
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_s;
    assign bus.lo   = lo_s;

endmodule

// File: tb/tb_multu_unit.sv
// Self-checking bench for multu_unit: directed scenarios plus random operands,
// checked against a plain-arithmetic product and latency model.
module tb_multu_unit;

    localparam int W = 32;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    multu_unit_if #(.WIDTH(W)) bus ();

    multu_unit #(.WIDTH(W), .CNT_W(6)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Cycle (relative to the start-sampling edge) on which done is expected.
    function automatic int exp_lat(input logic [W-1:0] b);
        int lat;
`ifdef MULTU_EARLY_EXIT_EN
        int top;
        top = -1;
        for (int i = 0; i < W; i++) if (b[i]) top = i;
        lat = 1 + (top + 1) + 1;
        if (lat > W + 1) lat = W + 1;
`else
        lat = W + 1;
`endif
        return lat;
    endfunction

    // Present operands with start at a falling edge; return at falling edge of cycle 1.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    // Check busy/done every cycle up to done and the HI/LO values at done.
    // inject > 0 pulses a stray start (a=1,b=1) on that cycle.
    task automatic check_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input int inject);
        logic [63:0] p;
        int          lat;
        p   = {32'd0, a} * {32'd0, b};
        lat = exp_lat(b);
        for (int c = 1; c <= lat; c++) begin
            if (c == inject) begin
                bus.start = 1'b1;
                bus.a     = 32'd1;
                bus.b     = 32'd1;
            end else begin
                bus.start = 1'b0;
            end
            if (c < lat) begin
                chk({tag, "_busy"}, {63'd0, bus.busy}, 64'd1);
                chk({tag, "_nodone"}, {63'd0, bus.done}, 64'd0);
                @(negedge clk);
            end else begin
                chk({tag, "_done"}, {63'd0, bus.done}, 64'd1);
                chk({tag, "_busy_lo"}, {63'd0, bus.busy}, 64'd0);
                chk({tag, "_hi"}, {32'd0, bus.hi}, {32'd0, p[63:32]});
                chk({tag, "_lo"}, {32'd0, bus.lo}, {32'd0, p[31:0]});
            end
        end
        bus.start = 1'b0;
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           dones;
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        chk("rst_hi", {32'd0, bus.hi}, 64'd0);
        chk("rst_lo", {32'd0, bus.lo}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(32'd3, 32'd5);
        check_op("basic", 32'd3, 32'd5, 0);
        @(negedge clk);
        chk("basic_idle_done", {63'd0, bus.done}, 64'd0);
        chk("basic_hold_lo", {32'd0, bus.lo}, 64'd15);

        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_op("full", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        @(negedge clk);
        issue(32'h8000_0000, 32'd2);
        check_op("msb", 32'h8000_0000, 32'd2, 0);
        @(negedge clk);

        // Stray start mid-operation is ignored; then back-to-back start in DONE.
        issue(32'd7, 32'd9);
        check_op("ignore", 32'd7, 32'd9, 10);
        issue(32'd2, 32'd4);
        check_op("b2b", 32'd2, 32'd4, 0);
        @(negedge clk);

        // Reset part-way through aborts and clears HI/LO.
        issue(32'd5, 32'd5);
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", {63'd0, bus.busy}, 64'd0);
        chk("abort_done", {63'd0, bus.done}, 64'd0);
        chk("abort_hi", {32'd0, bus.hi}, 64'd0);
        chk("abort_lo", {32'd0, bus.lo}, 64'd0);
        rst   = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        chk("abort_no_done", 64'(dones), 64'd0);

        issue(32'h1234, 32'd0);
        check_op("ee_b0", 32'h1234, 32'd0, 0);
        @(negedge clk);
        issue(32'h1234, 32'd1);
        check_op("ee_b1", 32'h1234, 32'd1, 0);
        @(negedge clk);

        // Random operands; multiplier shifted to vary its highest set bit.
        for (int n = 0; n < 10; n++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            issue(ra, rb);
            check_op("rand", ra, rb, 0);
            if (n[0]) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
